// File: rtl/if_stage_pkg.sv
// if_stage_pkg
// Shared constants, FSM state encoding and types for the instruction-fetch
// stage and its skid buffer.
//   INSTR_NOP    : addi x0,x0,0, shown to decode whenever no real instruction
//   RESET_PC_DEF : default first fetch address after reset
//   if_state_e   : fetch FSM states (IDLE, REQ, WAIT, DROP)
//   fetch_entry_t: one fetched instruction together with its PC
package if_stage_pkg;

   localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_REQ  = 2'd1,
      IF_WAIT = 2'd2,
      IF_DROP = 2'd3
   } if_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Instruction memory is word addressed; the low two address bits are
   // always forced to zero.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf
// One-entry holding buffer for a fetched {pc, instr} pair that arrived while
// the IF/ID register was stalled.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset (buffer empties)
//   clear      : drop any held entry (wrong-path squash); wins over wr/rd
//   wr, wr_data: capture an entry
//   rd         : release the held entry (consumer has taken rd_data)
//   full       : an entry is held
//   rd_data    : the held entry
module if_skid_buf
   import if_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         wr,
   input  fetch_entry_t wr_data,
   input  logic         rd,
   output logic         full,
   output fetch_entry_t rd_data
);

   logic         full_q;
   fetch_entry_t data_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full_q <= 1'b0;
      end else if (clear) begin
         full_q <= 1'b0;
      end else if (wr) begin
         full_q <= 1'b1;
      end else if (rd) begin
         full_q <= 1'b0;
      end
   end

   // Payload needs no reset: it is only looked at while full_q is set.
   always_ff @(posedge clk) begin
      if (wr) begin
         data_q <= wr_data;
      end
   end

   assign full    = full_q;
   assign rd_data = data_q;

endmodule

// File: rtl/if_stage.sv
// if_stage
// Instruction-fetch stage. Owns the PC, issues single-outstanding requests to
// instruction memory (req/gnt/rvalid), and drives the IF/ID register consumed
// by decode. Decode stalls are absorbed by a one-entry skid buffer; redirects
// from execute reload the PC and squash every wrong-path instruction.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   imem_req_o     : fetch request
//   imem_addr_o    : word-aligned fetch address
//   imem_gnt_i     : memory accepted the request this cycle
//   imem_rvalid_i  : response valid (at least one cycle after gnt)
//   imem_rdata_i   : instruction word
//   redirect_i     : taken branch / jump from execute
//   redirect_pc_i  : redirect target (bits [1:0] ignored)
//   stall_i        : decode cannot accept; hold IF/ID
//   instr_o, pc_o  : instruction to decode and its address
//   valid_o        : instr_o/pc_o hold a real instruction
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        stall_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        valid_o
);

   if_state_e    state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic         valid_q, valid_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pc_out_q, pc_out_d;

   logic         skid_full;
   logic         skid_wr;
   logic         skid_rd;
   fetch_entry_t skid_data;
   fetch_entry_t rsp_entry;

   logic         gnt_fire;
   logic         rsp_fire;
   logic         ifid_free;

   // No new request while the skid buffer holds an entry: with a single
   // outstanding fetch this guarantees a response never finds both the
   // IF/ID register and the skid buffer occupied.
   assign imem_req_o  = (state_q == IF_REQ) && !skid_full;
   assign imem_addr_o = word_align(pc_q);

   assign gnt_fire  = imem_req_o && imem_gnt_i;
   // Response that belongs to the current path (WAIT only; DROP discards,
   // and a same-cycle redirect squashes the data).
   assign rsp_fire  = (state_q == IF_WAIT) && imem_rvalid_i && !redirect_i;
   assign ifid_free = !valid_q || !stall_i;
   assign rsp_entry = {fetch_pc_q, imem_rdata_i};

   assign skid_wr = rsp_fire && !ifid_free;
   assign skid_rd = skid_full && ifid_free && !redirect_i;

   if_skid_buf u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (redirect_i),
      .wr      (skid_wr),
      .wr_data (rsp_entry),
      .rd      (skid_rd),
      .full    (skid_full),
      .rd_data (skid_data)
   );

   // Fetch FSM and PC.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fetch_pc_d = fetch_pc_q;
      case (state_q)
         IF_IDLE: begin
            state_d = IF_REQ;
         end
         IF_REQ: begin
            if (gnt_fire) begin
               fetch_pc_d = pc_q;
               pc_d       = pc_q + 32'd4;
               // A redirect in the grant cycle leaves a wrong-path fetch in
               // flight; its response must be thrown away.
               state_d    = redirect_i ? IF_DROP : IF_WAIT;
            end
         end
         IF_WAIT: begin
            if (imem_rvalid_i) begin
               state_d = IF_REQ;
            end else if (redirect_i) begin
               state_d = IF_DROP;
            end
         end
         IF_DROP: begin
            if (imem_rvalid_i) begin
               state_d = IF_REQ;
            end
         end
         default: begin
            state_d = IF_IDLE;
         end
      endcase
      // Redirect target overrides any increment from a same-cycle grant.
      if (redirect_i) begin
         pc_d = word_align(redirect_pc_i);
      end
   end

   // IF/ID register: redirect > stall hold > skid buffer > response > bubble.
   always_comb begin
      valid_d  = valid_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      if (redirect_i) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (valid_q && stall_i) begin
         valid_d  = valid_q;
      end else if (skid_full) begin
         valid_d  = 1'b1;
         instr_d  = skid_data.instr;
         pc_out_d = skid_data.pc;
      end else if (rsp_fire) begin
         valid_d  = 1'b1;
         instr_d  = imem_rdata_i;
         pc_out_d = fetch_pc_q;
      end else begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IF_IDLE;
         pc_q       <= RESET_PC;
         fetch_pc_q <= RESET_PC;
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_out_q   <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fetch_pc_q <= fetch_pc_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_out_q   <= pc_out_d;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_out_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage
// Bench for if_stage: an instruction-memory model answers requests with
// configurable grant delay and response latency; each non-squashed response
// pushes its expected {pc, instr} onto a scoreboard that is popped whenever
// decode takes an instruction. Directed scenario tasks add explicit checks.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        stall_i = 1'b0;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        valid_o;

   always #5 clk = ~clk;

   if_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .stall_i       (stall_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .valid_o       (valid_o)
   );

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t sb_q[$];

   // stimulus knobs
   logic        stall_v = 1'b0;
   logic        redir_v = 1'b0;
   logic [31:0] redir_pc_v = 32'h0;
   int          gnt_wait = 0;
   int          rsp_lat = 1;

   // memory / reference state
   bit          outstanding = 0;
   bit          squash = 0;
   int          rsp_cnt = 0;
   int          wait_cnt = 0;
   logic [31:0] out_addr = 32'h0;
   logic [31:0] out_pc = 32'h0;
   logic [31:0] exp_pc = 32'h0;
   bit          chk_redir = 0;
   bit          chk_rst = 0;
   bit          pend_req = 0;
   logic [31:0] pend_addr = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0050_0093 + (a << 10);
   endfunction

   // One clock cycle; called at a negedge, returns at the next negedge.
   task automatic step();
      bit   gnt;
      bit   rvalid;
      exp_t e;
      if (chk_rst) begin
         n_vec++;
         if (valid_o !== 1'b0 || instr_o !== NOP || pc_o !== 32'h0 || imem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: valid=%b instr=%h pc=%h req=%b, required 0/%h/00000000/0",
                     valid_o, instr_o, pc_o, imem_req_o, NOP);
         end
      end
      if (chk_redir) begin
         n_vec++;
         if (valid_o !== 1'b0 || instr_o !== NOP) begin
            n_err++;
            $display("FAIL redirect_flush: valid=%b instr=%h, required 0/%h", valid_o, instr_o, NOP);
         end
      end
      if (rst_n && valid_o === 1'b0) begin
         n_vec++;
         if (instr_o !== NOP) begin
            n_err++;
            $display("FAIL bubble_nop: instr=%h, required %h", instr_o, NOP);
         end
      end
      if (pend_req) begin
         n_vec++;
         if (imem_req_o !== 1'b1 || imem_addr_o !== pend_addr) begin
            n_err++;
            $display("FAIL req_hold: req=%b addr=%h, required 1/%h", imem_req_o, imem_addr_o, pend_addr);
         end
      end
      if (rst_n && outstanding) begin
         n_vec++;
         if (imem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_outstanding: req=%b while a fetch is in flight, required 0", imem_req_o);
         end
      end

      // memory response / grant for this cycle
      gnt = 0;
      rvalid = 0;
      if (rst_n) begin
         if (outstanding) begin
            rsp_cnt--;
            if (rsp_cnt == 0) rvalid = 1;
         end else if (imem_req_o === 1'b1) begin
            if (wait_cnt > 0) wait_cnt--;
            else gnt = 1;
         end
      end
      imem_gnt_i    = gnt;
      imem_rvalid_i = rvalid;
      imem_rdata_i  = rvalid ? mem_word(out_addr) : 32'hDEAD_BEEF;
      stall_i       = stall_v;
      redirect_i    = redir_v;
      redirect_pc_i = redir_pc_v;

      // decode takes the instruction at this edge
      if (rst_n && valid_o === 1'b1 && !stall_v && !redir_v) begin
         n_vec++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_spurious: got pc=%h instr=%h, required no valid instruction", pc_o, instr_o);
         end else begin
            e = sb_q.pop_front();
            if (pc_o !== e.pc || instr_o !== e.instr) begin
               n_err++;
               $display("FAIL sb_data: got pc=%h instr=%h, required pc=%h instr=%h",
                        pc_o, instr_o, e.pc, e.instr);
            end
         end
      end

      // reference update
      pend_req  = 0;
      chk_redir = 0;
      chk_rst   = 0;
      if (!rst_n) begin
         outstanding = 0;
         squash      = 0;
         sb_q.delete();
         exp_pc      = 32'h0;
         wait_cnt    = gnt_wait;
         chk_rst     = 1;
      end else begin
         if (redir_v) begin
            sb_q.delete();
            chk_redir = 1;
         end
         if (rvalid) begin
            outstanding = 0;
            if (!squash && !redir_v) begin
               e.pc    = out_pc;
               e.instr = mem_word(out_pc);
               sb_q.push_back(e);
            end
         end else if (outstanding && redir_v) begin
            squash = 1;
         end
         if (gnt) begin
            n_vec++;
            if (imem_addr_o !== exp_pc) begin
               n_err++;
               $display("FAIL fetch_addr: granted addr=%h, required %h", imem_addr_o, exp_pc);
            end
            out_addr    = imem_addr_o;
            out_pc      = exp_pc;
            outstanding = 1;
            squash      = redir_v;
            rsp_cnt     = rsp_lat;
            wait_cnt    = gnt_wait;
            exp_pc      = redir_v ? {redir_pc_v[31:2], 2'b00} : exp_pc + 32'd4;
         end else begin
            if (redir_v) exp_pc = {redir_pc_v[31:2], 2'b00};
            if (imem_req_o === 1'b1 && !redir_v) begin
               pend_req  = 1;
               pend_addr = imem_addr_o;
            end
         end
      end
      $display("cyc: rst_n=%b req=%b addr=%h gnt=%b rvalid=%b stall=%b redir=%b valid=%b pc=%h instr=%h",
               rst_n, imem_req_o, imem_addr_o, gnt, rvalid, stall_v, redir_v, valid_o, pc_o, instr_o);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      rst_n   = 1'b0;
      stall_v = 1'b0;
      redir_v = 1'b0;
      repeat (cycles) step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(2);
      n_vec++;
      if (valid_o !== 1'b0 || instr_o !== NOP || pc_o !== 32'h0 || imem_req_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: valid=%b instr=%h pc=%h req=%b, required 0/%h/00000000/0",
                  valid_o, instr_o, pc_o, imem_req_o, NOP);
      end
      step();
      n_vec++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
         n_err++;
         $display("FAIL first_req: req=%b addr=%h, required 1/00000000", imem_req_o, imem_addr_o);
      end
   endtask

   task automatic test_zero_wait();
      step();
      n_vec++;
      if (imem_req_o !== 1'b0) begin
         n_err++;
         $display("FAIL wait_noreq: req=%b, required 0", imem_req_o);
      end
      step();
      n_vec++;
      if (valid_o !== 1'b1 || instr_o !== 32'h0050_0093 || pc_o !== 32'h0) begin
         n_err++;
         $display("FAIL first_instr: valid=%b instr=%h pc=%h, required 1/00500093/00000000",
                  valid_o, instr_o, pc_o);
      end
      n_vec++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
         n_err++;
         $display("FAIL second_req: req=%b addr=%h, required 1/00000004", imem_req_o, imem_addr_o);
      end
      repeat (10) step();
   endtask

   task automatic test_stall();
      logic [31:0] h_instr;
      logic [31:0] h_pc;
      rsp_lat = 1;
      gnt_wait = 0;
      do_reset(1);
      repeat (3) step();
      n_vec++;
      if (valid_o !== 1'b1) begin
         n_err++;
         $display("FAIL stall_pre: valid=%b, required 1", valid_o);
      end
      h_instr = instr_o;
      h_pc    = pc_o;
      stall_v = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_vec++;
         if (valid_o !== 1'b1 || instr_o !== h_instr || pc_o !== h_pc) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc=%h, required 1/%h/%h",
                     i, valid_o, instr_o, pc_o, h_instr, h_pc);
         end
      end
      n_vec++;
      if (imem_req_o !== 1'b0) begin
         n_err++;
         $display("FAIL skid_full_noreq: req=%b, required 0", imem_req_o);
      end
      stall_v = 1'b0;
      step();
      n_vec++;
      if (valid_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== mem_word(32'h4)) begin
         n_err++;
         $display("FAIL skid_release: valid=%b pc=%h instr=%h, required 1/00000004/%h",
                  valid_o, pc_o, instr_o, mem_word(32'h4));
      end
      repeat (8) step();
   endtask

   task automatic test_redirect_wait();
      rsp_lat = 3;
      do_reset(1);
      step();
      step();
      redir_v    = 1'b1;
      redir_pc_v = 32'h0000_0103;
      step();
      redir_v = 1'b0;
      step();
      step();
      n_vec++;
      if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
         n_err++;
         $display("FAIL redir_drop: valid=%b req=%b addr=%h, required 0/1/00000100",
                  valid_o, imem_req_o, imem_addr_o);
      end
      rsp_lat = 2;
      step();
      step();
      redir_v    = 1'b1;
      redir_pc_v = 32'h0000_0200;
      step();
      redir_v = 1'b0;
      n_vec++;
      if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
         n_err++;
         $display("FAIL redir_rvalid: valid=%b req=%b addr=%h, required 0/1/00000200",
                  valid_o, imem_req_o, imem_addr_o);
      end
      rsp_lat = 1;
      repeat (6) step();
   endtask

   task automatic test_redirect_stall();
      rsp_lat = 1;
      do_reset(1);
      repeat (3) step();
      n_vec++;
      if (valid_o !== 1'b1) begin
         n_err++;
         $display("FAIL rs_pre: valid=%b, required 1", valid_o);
      end
      stall_v    = 1'b1;
      redir_v    = 1'b1;
      redir_pc_v = 32'h0000_0040;
      step();
      stall_v = 1'b0;
      redir_v = 1'b0;
      n_vec++;
      if (valid_o !== 1'b0 || instr_o !== NOP) begin
         n_err++;
         $display("FAIL rs_flush: valid=%b instr=%h, required 0/%h", valid_o, instr_o, NOP);
      end
      step();
      n_vec++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
         n_err++;
         $display("FAIL rs_restart: req=%b addr=%h, required 1/00000040", imem_req_o, imem_addr_o);
      end
      repeat (6) step();
   endtask

   task automatic test_gnt_wait();
      gnt_wait = 5;
      do_reset(1);
      step();
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_err++;
            $display("FAIL gnt_wait[%0d]: req=%b addr=%h, required 1/00000000", i, imem_req_o, imem_addr_o);
         end
         step();
      end
      step();
      gnt_wait = 0;
      wait_cnt = 0;
      step();
      n_vec++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
         n_err++;
         $display("FAIL gnt_wait_adv: req=%b addr=%h, required 1/00000004", imem_req_o, imem_addr_o);
      end
      repeat (6) step();
   endtask

   task automatic test_reset_wait();
      rsp_lat = 1;
      do_reset(1);
      repeat (3) step();
      rsp_lat = 3;
      stall_v = 1'b1;
      step();
      n_vec++;
      if (valid_o !== 1'b1 || imem_req_o !== 1'b0) begin
         n_err++;
         $display("FAIL rw_pre: valid=%b req=%b, required 1/0", valid_o, imem_req_o);
      end
      stall_v = 1'b0;
      rst_n   = 1'b0;
      step();
      n_vec++;
      if (valid_o !== 1'b0 || instr_o !== NOP || pc_o !== 32'h0 || imem_req_o !== 1'b0) begin
         n_err++;
         $display("FAIL rw_reset: valid=%b instr=%h pc=%h req=%b, required 0/%h/00000000/0",
                  valid_o, instr_o, pc_o, imem_req_o, NOP);
      end
      rst_n   = 1'b1;
      rsp_lat = 1;
      step();
      n_vec++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
         n_err++;
         $display("FAIL rw_restart: req=%b addr=%h, required 1/00000000", imem_req_o, imem_addr_o);
      end
      repeat (6) step();
   endtask

   task automatic test_wrap();
      redir_v    = 1'b1;
      redir_pc_v = 32'hFFFF_FFFE;
      step();
      redir_v = 1'b0;
      repeat (10) step();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 400; i++) begin
         stall_v    = ($urandom_range(0, 3) == 0);
         redir_v    = ($urandom_range(0, 19) == 0);
         redir_pc_v = $urandom;
         gnt_wait   = $urandom_range(0, 2);
         rsp_lat    = $urandom_range(1, 3);
         step();
      end
      stall_v  = 1'b0;
      redir_v  = 1'b0;
      gnt_wait = 0;
      rsp_lat  = 1;
      repeat (8) step();
      n_vec++;
      if (sb_q.size() != (valid_o === 1'b1 ? 1 : 0)) begin
         n_err++;
         $display("FAIL sb_drain: %0d pending with valid=%b, required %0d",
                  sb_q.size(), valid_o, (valid_o === 1'b1 ? 1 : 0));
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_zero_wait();
      test_stall();
      test_redirect_wait();
      test_redirect_stall();
      test_gnt_wait();
      test_reset_wait();
      test_wrap();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
